// File: rtl/bnn_stream_frontend.sv
// bnn_stream_frontend
// Streams quantized features into the parallel input bus of a sequential BNN
// core, restarts the core once a full frame is packed, waits out the fixed
// inference time and offers the captured class index on a valid/ready output.
// Frames whose s_last marker does not land on the final feature are dropped
// and flagged with a one-cycle frame_err pulse.
module bnn_stream_frontend #(
    parameter int FEAT_CNT     = 12,
    parameter int FEAT_BITS    = 4,
    parameter int CLASS_CNT    = 6,
    parameter int INFER_CYCLES = 48,
    localparam int PW          = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [FEAT_BITS-1:0]          s_data,
    input  logic                          s_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          core_rst,
    input  logic [PW-1:0]                 prediction,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [PW-1:0]                 m_class,
    output logic                          frame_err
);

    localparam int KW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int CW = $clog2(INFER_CYCLES + 1);

    localparam logic [KW-1:0] LAST_BEAT  = KW'(FEAT_CNT - 1);
    localparam logic [CW-1:0] INFER_LOAD = CW'(INFER_CYCLES);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] beat_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          accept;
    logic          last_slot;

    assign accept    = s_valid && s_ready && (state == ST_LOAD);
    assign last_slot = (beat_cnt == LAST_BEAT);

    // Frame sequencing: beat counting, framing checks, core restart, inference timer and result handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            beat_cnt  <= '0;
            cyc_cnt   <= '0;
            s_ready   <= 1'b0;
            core_rst  <= 1'b0;
            m_valid   <= 1'b0;
            m_class   <= '0;
            frame_err <= 1'b0;
        end else begin
            core_rst  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_LOAD: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (s_last != last_slot) begin
                            frame_err <= 1'b1;
                            beat_cnt  <= '0;
                        end else if (last_slot) begin
                            state    <= ST_RUN;
                            s_ready  <= 1'b0;
                            core_rst <= 1'b1;
                            cyc_cnt  <= INFER_LOAD;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_rst) begin
                        cyc_cnt <= cyc_cnt;
                    end else if (cyc_cnt <= CW'(1)) begin
                        cyc_cnt <= '0;
                        m_class <= prediction;
                        m_valid <= 1'b1;
                        state   <= ST_OUT;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        s_ready  <= 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_LOAD;
                    end
                end
                default: begin
                    state   <= ST_LOAD;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    // Feature bus: each accepted beat overwrites its own slot, other slots keep the previous frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            features <= '0;
        end else if (accept) begin
            features[int'(beat_cnt)*FEAT_BITS +: FEAT_BITS] <= s_data;
        end
    end

endmodule

// File: tb/tb_bnn_stream_frontend.sv
// tb_bnn_stream_frontend
// Directed bench for bnn_stream_frontend: frame packing, restart pulse,
// inference latency, framing errors, output back-pressure and mid-run reset.
module tb_bnn_stream_frontend;

    localparam int FEAT_CNT     = 12;
    localparam int FEAT_BITS    = 4;
    localparam int CLASS_CNT    = 6;
    localparam int INFER_CYCLES = 48;
    localparam int PW           = 3;
    localparam int LATENCY      = INFER_CYCLES + 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          s_valid;
    logic                          s_ready;
    logic [FEAT_BITS-1:0]          s_data;
    logic                          s_last;
    logic [FEAT_CNT*FEAT_BITS-1:0] features;
    logic                          core_rst;
    logic [PW-1:0]                 prediction;
    logic                          m_valid;
    logic                          m_ready;
    logic [PW-1:0]                 m_class;
    logic                          frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int core_rst_seen  = 0;
    int frame_err_seen = 0;
    int last_accept_cyc = 0;

    logic [FEAT_BITS-1:0] frame_data [FEAT_CNT];

    bnn_stream_frontend #(
        .FEAT_CNT    (FEAT_CNT),
        .FEAT_BITS   (FEAT_BITS),
        .CLASS_CNT   (CLASS_CNT),
        .INFER_CYCLES(INFER_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .features  (features),
        .core_rst  (core_rst),
        .prediction(prediction),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_class   (m_class),
        .frame_err (frame_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter and pulse counters for core_rst and frame_err.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_rst)  core_rst_seen  <= core_rst_seen + 1;
        if (frame_err) frame_err_seen <= frame_err_seen + 1;
    end

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_up();
        for (int i = 0; i < FEAT_CNT; i++) frame_data[i] = 4'(i + 1);
    endtask

    task automatic load_down();
        for (int i = 0; i < FEAT_CNT; i++) frame_data[i] = 4'(15 - i);
    endtask

    // Offer one beat (optionally after an idle cycle) and wait until it is taken.
    task automatic applyStimulus(input logic [3:0] data, input logic last, input bit gap);
        bit rdy;
        bit done;
        done = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            s_data  = ~data;
            s_last  = ~last;
            step();
        end
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                done = 1'b1;
                last_accept_cyc = cyc;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!done) checkOutput("beat_accept", 64'(done), 64'd1);
    endtask

    task automatic send_frame(input int n_beats, input int last_idx, input bit gaps);
        for (int i = 0; i < n_beats; i++) applyStimulus(frame_data[i], (i == last_idx), gaps);
    endtask

    // Full frame through to m_valid; returns at the cycle m_valid is first seen.
    task automatic run_frame(input string tag, input logic [47:0] exp_feat, input logic [2:0] pred, input bit gaps);
        int  rst_base;
        int  lat;
        bit  seen;
        rst_base = core_rst_seen;
        prediction = pred;
        seen = 1'b0;
        lat  = 0;
        send_frame(FEAT_CNT, FEAT_CNT - 1, gaps);
        checkOutput({tag, "_features"}, 64'(features), 64'(exp_feat));
        checkOutput({tag, "_core_rst_hi"}, 64'(core_rst), 64'd1);
        checkOutput({tag, "_s_ready_run"}, 64'(s_ready), 64'd0);
        step();
        checkOutput({tag, "_core_rst_lo"}, 64'(core_rst), 64'd0);
        for (int i = 0; i < 200 && !seen; i++) begin
            if (m_valid) begin
                seen = 1'b1;
                lat  = cyc - last_accept_cyc;
            end else begin
                step();
            end
        end
        checkOutput({tag, "_m_valid_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({tag, "_m_class"}, 64'(m_class), 64'(pred));
        checkOutput({tag, "_features_held"}, 64'(features), 64'(exp_feat));
        checkOutput({tag, "_core_rst_pulses"}, 64'(core_rst_seen - rst_base), 64'd1);
    endtask

    task automatic handshake(input string tag);
        m_ready = 1'b1;
        step();
        checkOutput({tag, "_m_valid_drop"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_s_ready_back"}, 64'(s_ready), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        checkOutput({tag, "_features"}, 64'(features), 64'd0);
        checkOutput({tag, "_core_rst"}, 64'(core_rst), 64'd0);
        checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_m_class"}, 64'(m_class), 64'd0);
        checkOutput({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        int  rst_base;
        int  err_base;
        bit  spurious;

        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        m_ready    = 1'b0;
        prediction = '0;

        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        checkOutput("release_s_ready", 64'(s_ready), 64'd1);

        // Plain frame 1..C, consumer ready from the start
        load_up();
        m_ready = 1'b1;
        run_frame("t1", 48'hCBA987654321, 3'd5, 1'b0);
        handshake("t1");

        // Same frame with idle cycles between beats
        run_frame("t2", 48'hCBA987654321, 3'd2, 1'b1);
        handshake("t2");
        m_ready = 1'b0;

        // Early s_last on beat 5, then a clean frame
        load_down();
        rst_base = core_rst_seen;
        err_base = frame_err_seen;
        send_frame(5, 4, 1'b0);
        checkOutput("t3_frame_err_hi", 64'(frame_err), 64'd1);
        step();
        checkOutput("t3_frame_err_lo", 64'(frame_err), 64'd0);
        checkOutput("t3_s_ready", 64'(s_ready), 64'd1);
        checkOutput("t3_err_pulses", 64'(frame_err_seen - err_base), 64'd1);
        checkOutput("t3_no_core_rst", 64'(core_rst_seen - rst_base), 64'd0);
        run_frame("t3", 48'h456789ABCDEF, 3'd1, 1'b0);
        handshake("t3");
        m_ready = 1'b0;

        // Twelve beats with no s_last
        rst_base = core_rst_seen;
        err_base = frame_err_seen;
        send_frame(FEAT_CNT, -1, 1'b0);
        checkOutput("t4_frame_err_hi", 64'(frame_err), 64'd1);
        step();
        checkOutput("t4_frame_err_lo", 64'(frame_err), 64'd0);
        repeat (5) step();
        checkOutput("t4_s_ready", 64'(s_ready), 64'd1);
        checkOutput("t4_m_valid", 64'(m_valid), 64'd0);
        checkOutput("t4_err_pulses", 64'(frame_err_seen - err_base), 64'd1);
        checkOutput("t4_no_core_rst", 64'(core_rst_seen - rst_base), 64'd0);

        // Output back-pressure for 20 cycles
        load_up();
        run_frame("t5", 48'hCBA987654321, 3'd4, 1'b0);
        prediction = 3'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("t5_stall_m_valid", 64'(m_valid), 64'd1);
            checkOutput("t5_stall_m_class", 64'(m_class), 64'd4);
            checkOutput("t5_stall_s_ready", 64'(s_ready), 64'd0);
        end
        handshake("t5");
        m_ready = 1'b0;

        // Reset in the middle of an inference
        prediction = 3'd3;
        send_frame(FEAT_CNT, FEAT_CNT - 1, 1'b0);
        repeat (10) step();
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        spurious = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (m_valid) spurious = 1'b1;
        end
        checkOutput("t6_no_result", 64'(spurious), 64'd0);
        rst = 1'b1;
        step();
        checkOutput("t6_release_s_ready", 64'(s_ready), 64'd1);
        load_down();
        run_frame("t6", 48'h456789ABCDEF, 3'd3, 1'b0);
        handshake("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
